drv_ad56x3_spi: RTL and testbench
=================================

Name: drv_ad56x3_spi

Overview:
Two-channel Avalon-ST sink that takes signed DAC samples and serialises them into 24-bit SPI write frames for an AD56x3 dual DAC. It is the consumer end of the streams produced by the saw generator and by other sample sources. Each channel has a one-entry holding buffer. A frame engine arbitrates between the two channels and drives SCLK, SYNC and DIN.

Parameters:
DATA_WIDTH, 14, sample width; legal values are 12, 14 and 16.
SCLK_HALF, 2, clk cycles per SCLK half-period; must be 1 or more.
SYNC_GAP, 4, minimum clk cycles SYNC stays high between frames; must be 1 or more.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active-low
valid0  in  1  channel 0 (DAC A) sample valid
data0  in  DATA_WIDTH  channel 0 signed sample
rdy0  out  1  channel 0 ready
valid1  in  1  channel 1 (DAC B) sample valid
data1  in  DATA_WIDTH  channel 1 signed sample
rdy1  out  1  channel 1 ready
dacSclk  out  1  SPI clock, idles high
dacSyncN  out  1  frame select, active-low
dacDin  out  1  serial data, MSB first
busy  out  1  high while a frame is in progress, including the gap
frameDone  out  1  one-cycle pulse after the last bit of each frame

Behaviour:
- Clock and reset: single clock domain clk. Reset is asynchronous, active-low on reset_n.
- Reset values:
  - Both buffers empty.
  - State IDLE.
  - dacSclk=1, dacSyncN=1, dacDin=0, busy=0, frameDone=0.
  - Round-robin pointer selects channel 0.
- Ready and accept:
  - rdyN = ~fullN, a combinational function of a registered flag. It is therefore 1 from reset.
  - A sample is accepted when validN & rdyN on a rising clk edge. This sets fullN and latches the sample.
  - data is ignored when valid is low.
- Buffer release: fullN clears on the cycle the engine loads that channel's shift register. A new sample can be accepted on that same edge only if rdyN was already high, so there is no same-cycle bypass.
- Sample conversion: invert the sample MSB (signed to offset binary), then left-align into 16 bits with zero LSB padding.
- Frame word, 24 bits: 2'b00, command 3'b011 (write and update channel n), address 3'b000 for channel 0 or 3'b001 for channel 1, then the 16-bit data.
- Outputs: all SPI outputs are registered.
- FSM:
  - IDLE: if any buffer is full, go to LOAD. If both are full, pick the channel named by the round-robin pointer, then toggle the pointer. If only one is full, pick it and set the pointer to the other channel.
  - LOAD (1 cycle): shift register <= frame word, clear the chosen fullN, dacSyncN<=0, busy<=1, dacDin<=bit 23.
  - SHIFT: each bit occupies 2*SCLK_HALF cycles. For SCLK_HALF cycles dacSclk=1 with DIN stable, then for SCLK_HALF cycles dacSclk=0. The DAC samples on the falling edge. DIN advances to the next bit on the rising edge of dacSclk. Repeat for 24 bits with a 5-bit bit counter and a clk-divider counter.
  - After bit 0's low half: dacSclk<=1, dacSyncN<=1, frameDone pulses, go to GAP.
  - GAP: hold for SYNC_GAP cycles, then busy<=0 and return to IDLE.
  - Frame period = 1 + 48*SCLK_HALF + SYNC_GAP cycles; 101 at the defaults.
- Boundary rules:
  - Samples arriving during SHIFT or GAP are buffered, and rdy drops.
  - A second sample on a full channel stalls upstream and is never overwritten.
  - Both channels becoming full on the same edge: the pointer decides, and both are sent back-to-back.
  - reset_n asserted mid-frame aborts immediately: dacSyncN=1, dacSclk=1, buffers flushed. No partial frame completes.

Test Plan:
1. Single sample at defaults: data0=14'sh0000 -> one frame with dacSyncN low for 96 SCLK-phase cycles; 24 bits captured on falling edges = 24'h188000; frameDone pulses once; busy low 101 cycles after LOAD.
2. Channel 1 negative and full-scale conversion: data1=14'sh3FFF (-1) -> frame 24'h197FFC; data0=14'sh1FFF -> 24'h18FFFC; data0=14'sh2000 -> 24'h180000.
3. Arbitration: valid0 and valid1 in the same cycle with 0x0100 and 0x0200 -> channel 0 frame first, then channel 1; a second simultaneous pair -> channel 1 frame first. SYNC high exactly 4 cycles between frames.
4. Backpressure: hold valid0 high with an incrementing sample for 5 frames -> rdy0 low whenever full; no sample lost or duplicated; the captured sequence matches the input.
5. Reset mid-frame: deassert reset_n at bit 10 -> dacSyncN=1 and dacSclk=1 asynchronously; after release, rdy0=rdy1=1 and no frame starts without new valid.
6. Parameter sweep: SCLK_HALF=1, SYNC_GAP=1, DATA_WIDTH=16, data0=16'sh8000 -> frame 24'h180000 with period 50 cycles; DATA_WIDTH=12, data1=12'sh7FF -> 24'h19FFF0.

Source files
------------

// File: rtl/drv_ad56x3_spi.sv
// drv_ad56x3_spi
// Two-channel Avalon-ST sink that serialises signed DAC samples into 24-bit
// SPI write frames for an AD56x3 dual DAC. Each channel has a one-entry
// holding buffer. A round-robin frame engine drives SCLK, SYNC and DIN.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous reset, active-low
//   valid0/1   channel sample valid (0 = DAC A, 1 = DAC B)
//   data0/1    channel signed sample, DATA_WIDTH bits
//   rdy0/1     channel ready (buffer empty)
//   dacSclk    SPI clock, idles high
//   dacSyncN   frame select, active-low
//   dacDin     serial data, MSB first
//   busy       high from frame load through the end of the SYNC gap
//   frameDone  one-cycle pulse after the last bit of each frame
module drv_ad56x3_spi #(
    parameter int DATA_WIDTH = 14,
    parameter int SCLK_HALF  = 2,
    parameter int SYNC_GAP   = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid0,
    input  logic signed [DATA_WIDTH-1:0] data0,
    output logic                         rdy0,
    input  logic                         valid1,
    input  logic signed [DATA_WIDTH-1:0] data1,
    output logic                         rdy1,
    output logic                         dacSclk,
    output logic                         dacSyncN,
    output logic                         dacDin,
    output logic                         busy,
    output logic                         frameDone
);

    localparam int DIV_W = $clog2(2 * SCLK_HALF) + 1;
    localparam int GAP_W = $clog2(SYNC_GAP) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_HALF);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);
    localparam logic [4:0]       BIT_LAST = 5'd23;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    // Signed to offset binary (flip MSB), left-aligned in 16 bits.
    function automatic logic [15:0] to_offset16(input logic signed [DATA_WIDTH-1:0] s);
        logic [15:0] r;
        r = '0;
        r[15 -: DATA_WIDTH] = s;
        r[15] = ~r[15];
        return r;
    endfunction

    state_t                  state_q;
    logic                    rr_q;
    logic [4:0]              bit_q;
    logic [DIV_W-1:0]        div_q;
    logic [GAP_W-1:0]        gap_q;
    logic                    sclk_q, sync_q, din_q, busy_q, done_q;
    logic [22:0]             sreg_q;
    logic                    full0_q, full0_d, full1_q, full1_d;
    logic signed [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

    logic                    acc0, acc1, clr0, clr1;
    logic                    gap_end, start, pick1, shift_adv;
    logic [DIV_W-1:0]        div_inc;
    logic [23:0]             frame_w;

    assign rdy0 = ~full0_q;
    assign rdy1 = ~full1_q;
    assign acc0 = valid0 & ~full0_q;
    assign acc1 = valid1 & ~full1_q;

    // A new frame may start from IDLE or straight out of the last GAP cycle,
    // so back-to-back frames keep SYNC high for exactly SYNC_GAP cycles.
    assign gap_end = (state_q == GAP) && (gap_q == GAP_LAST);
    assign start   = ((state_q == IDLE) || gap_end) && (full0_q || full1_q);
    // rr_q = 1 means channel 1 has priority when both buffers are full.
    assign pick1   = full1_q && (!full0_q || rr_q);
    assign clr0    = start & ~pick1;
    assign clr1    = start & pick1;
    assign frame_w = {2'b00, 3'b011, 2'b00, pick1, to_offset16(pick1 ? buf1_q : buf0_q)};

    assign div_inc   = div_q + DIV_W'(1);
    assign shift_adv = (state_q == SHIFT) && (div_q == DIV_LAST) && (bit_q != BIT_LAST);

    // A full buffer is only released by a load, and a load only clears a
    // full buffer, so accept and clear never collide on one edge.
    always_comb begin
        full0_d = full0_q;
        full1_d = full1_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        if (clr0) full0_d = 1'b0;
        if (clr1) full1_d = 1'b0;
        if (acc0) begin
            full0_d = 1'b1;
            buf0_d  = data0;
        end
        if (acc1) begin
            full1_d = 1'b1;
            buf1_d  = data1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
        end
    end

    // Sample and shift storage carry no reset; the full flags and FSM gate them.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
        if (start)
            sreg_q <= frame_w[22:0];
        else if (shift_adv)
            sreg_q <= {sreg_q[21:0], 1'b0};
    end

    // Frame engine. The LOAD cycle already presents SYNC low and bit 23 with
    // SCLK high; each SHIFT bit then spends SCLK_HALF cycles high and
    // SCLK_HALF cycles low, DIN advancing when SCLK returns high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q <= LOAD;
                rr_q    <= ~pick1;
                sclk_q  <= 1'b1;
                sync_q  <= 1'b0;
                busy_q  <= 1'b1;
                din_q   <= frame_w[23];
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    LOAD: begin
                        state_q <= SHIFT;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                    SHIFT: begin
                        if (div_q == DIV_LAST) begin
                            div_q  <= '0;
                            sclk_q <= 1'b1;
                            if (bit_q == BIT_LAST) begin
                                sync_q  <= 1'b1;
                                done_q  <= 1'b1;
                                gap_q   <= '0;
                                state_q <= GAP;
                            end else begin
                                bit_q <= bit_q + 5'd1;
                                din_q <= sreg_q[22];
                            end
                        end else begin
                            div_q  <= div_inc;
                            sclk_q <= (div_inc < DIV_HALF);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dacSclk   = sclk_q;
    assign dacSyncN  = sync_q;
    assign dacDin    = din_q;
    assign busy      = busy_q;
    assign frameDone = done_q;

endmodule

// File: tb/tb_drv_ad56x3_spi.sv
// tb_drv_ad56x3_spi
// Self-checking bench for drv_ad56x3_spi. Three instances: defaults (a),
// DATA_WIDTH=16/SCLK_HALF=1/SYNC_GAP=1 (b) and DATA_WIDTH=12 (c). Expected
// frames are queued when samples are driven and popped by an SPI monitor
// that shifts DIN in on every falling SCLK while SYNC is low.
module tb_drv_ad56x3_spi;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;

    logic v0a = 0, v1a = 0, r0a, r1a, sclka, synca, dina, busya, donea;
    logic signed [13:0] d0a = '0, d1a = '0;
    logic v0b = 0, v1b = 0, r0b, r1b, sclkb, syncb, dinb, busyb, doneb;
    logic signed [15:0] d0b = '0, d1b = '0;
    logic v0c = 0, v1c = 0, r0c, r1c, sclkc, syncc, dinc, busyc, donec;
    logic signed [11:0] d0c = '0, d1c = '0;

    drv_ad56x3_spi #(.DATA_WIDTH(14), .SCLK_HALF(2), .SYNC_GAP(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .valid0(v0a), .data0(d0a), .rdy0(r0a),
        .valid1(v1a), .data1(d1a), .rdy1(r1a), .dacSclk(sclka), .dacSyncN(synca),
        .dacDin(dina), .busy(busya), .frameDone(donea));
    drv_ad56x3_spi #(.DATA_WIDTH(16), .SCLK_HALF(1), .SYNC_GAP(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .valid0(v0b), .data0(d0b), .rdy0(r0b),
        .valid1(v1b), .data1(d1b), .rdy1(r1b), .dacSclk(sclkb), .dacSyncN(syncb),
        .dacDin(dinb), .busy(busyb), .frameDone(doneb));
    drv_ad56x3_spi #(.DATA_WIDTH(12), .SCLK_HALF(2), .SYNC_GAP(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .valid0(v0c), .data0(d0c), .rdy0(r0c),
        .valid1(v1c), .data1(d1c), .rdy1(r1c), .dacSclk(sclkc), .dacSyncN(syncc),
        .dacDin(dinc), .busy(busyc), .frameDone(donec));

    int n_vec = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    // Monitor selection and state
    int   mon_sel = 0;
    int   m_half;
    logic m_sclk, m_sync, m_din, m_done, m_busy;
    int   nb = 0;
    int   low_cnt = 0;
    int   done_cnt = 0;
    logic sclk_prev = 1'b1;
    logic [23:0] shreg = '0;
    logic [23:0] mon_e;

    always_comb begin
        m_sclk = sclka; m_sync = synca; m_din = dina; m_done = donea; m_busy = busya; m_half = 2;
        if (mon_sel == 1) begin
            m_sclk = sclkb; m_sync = syncb; m_din = dinb; m_done = doneb; m_busy = busyb; m_half = 1;
        end else if (mon_sel == 2) begin
            m_sclk = sclkc; m_sync = syncc; m_din = dinc; m_done = donec; m_busy = busyc; m_half = 2;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            nb = 0; low_cnt = 0; shreg = '0; sclk_prev = 1'b1;
        end else begin
            if (!m_sync) begin
                if (sclk_prev && !m_sclk) begin
                    shreg = {shreg[22:0], m_din};
                    nb++;
                end
                if (!m_sclk) low_cnt++;
            end
            sclk_prev = m_sclk;
            if (m_done) begin
                done_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_unexpected: got %06h (%0d bits), required no frame", shreg, nb);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (nb !== 24 || shreg !== mon_e) begin
                        n_err++;
                        $display("FAIL frame: got %06h (%0d bits), required %06h (24 bits)", shreg, nb, mon_e);
                    end
                end
                n_vec++;
                if (low_cnt !== 24 * m_half) begin
                    n_err++;
                    $display("FAIL sclk_low_cycles: got %0d, required %0d", low_cnt, 24 * m_half);
                end
                nb = 0; low_cnt = 0;
            end
        end
    end

    function automatic logic [23:0] exp_frame(input int ch, input int val, input int w);
        int off;
        logic [23:0] r;
        off = (val ^ (1 << (w - 1))) & ((1 << w) - 1);
        r = 24'h180000;
        r[16] = (ch != 0);
        r[15:0] = 16'(off << (16 - w));
        return r;
    endfunction

    function automatic logic get_rdy(input int inst, input int ch);
        case (inst)
            1: return (ch == 0) ? r0b : r1b;
            2: return (ch == 0) ? r0c : r1c;
            default: return (ch == 0) ? r0a : r1a;
        endcase
    endfunction

    task automatic set_in(input int inst, input int ch, input logic v, input int val);
        case (inst)
            1: if (ch == 0) begin v0b = v; d0b = 16'(val); end else begin v1b = v; d1b = 16'(val); end
            2: if (ch == 0) begin v0c = v; d0c = 12'(val); end else begin v1c = v; d1c = 12'(val); end
            default: if (ch == 0) begin v0a = v; d0a = 14'(val); end else begin v1a = v; d1a = 14'(val); end
        endcase
    endtask

    // Present one sample, hold valid until it is accepted, queue its frame.
    task automatic send(input int inst, input int ch, input int val, input bit push, input logic [23:0] e);
        int t;
        t = 0;
        @(negedge clk);
        set_in(inst, ch, 1'b1, val);
        while (!get_rdy(inst, ch) && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: rdy%0d stayed 0 for %0d cycles, required 1", ch, t);
        end else if (push) begin
            exp_q.push_back(e);
        end
        @(negedge clk);
        set_in(inst, ch, 1'b0, val);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (!(!m_busy && get_rdy(mon_sel, 0) && get_rdy(mon_sel, 1) && exp_q.size() == 0) && t < 3000) begin
            @(negedge clk); t++;
        end
        n_vec++;
        if (t >= 3000) begin
            n_err++;
            $display("FAIL %s_idle: busy=%0d pending=%0d, required busy=0 pending=0", tag, m_busy, exp_q.size());
        end
    endtask

    task automatic measure_busy(input string tag, input int required);
        int t, cnt;
        t = 0; cnt = 0;
        while (!m_busy && t < 50) begin @(negedge clk); t++; end
        while (m_busy && cnt < 1000) begin @(negedge clk); cnt++; end
        n_vec++;
        if (cnt !== required) begin
            n_err++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", tag, cnt, required);
        end
    endtask

    task automatic measure_gap(input string tag);
        int t, g;
        t = 0; g = 0;
        while (!m_done && t < 1000) begin @(negedge clk); t++; end
        while (m_sync && g < 50) begin g++; @(negedge clk); end
        n_vec++;
        if (g !== 4) begin
            n_err++;
            $display("FAIL %s_sync_gap: got %0d cycles, required 4", tag, g);
        end
    endtask

    task automatic send_pair(input int val0, input int val1, input bit ch1_first);
        @(negedge clk);
        v0a = 1'b1; d0a = 14'(val0); v1a = 1'b1; d1a = 14'(val1);
        n_vec++;
        if (!(r0a && r1a)) begin
            n_err++;
            $display("FAIL pair_ready: rdy0=%0d rdy1=%0d, required 1 1", r0a, r1a);
        end
        if (ch1_first) begin
            exp_q.push_back(exp_frame(1, val1, 14)); exp_q.push_back(exp_frame(0, val0, 14));
        end else begin
            exp_q.push_back(exp_frame(0, val0, 14)); exp_q.push_back(exp_frame(1, val1, 14));
        end
        @(negedge clk);
        v0a = 1'b0; v1a = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 7;
        if (sclka !== 1'b1) begin n_err++; $display("FAIL reset_sclk: got %b, required 1", sclka); end
        if (synca !== 1'b1) begin n_err++; $display("FAIL reset_sync: got %b, required 1", synca); end
        if (dina !== 1'b0) begin n_err++; $display("FAIL reset_din: got %b, required 0", dina); end
        if (busya !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busya); end
        if (donea !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", donea); end
        if (r0a !== 1'b1) begin n_err++; $display("FAIL reset_rdy0: got %b, required 1", r0a); end
        if (r1a !== 1'b1) begin n_err++; $display("FAIL reset_rdy1: got %b, required 1", r1a); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busya !== 1'b0 || synca !== 1'b1) begin
            n_err++; $display("FAIL reset_release_idle: busy=%b sync=%b, required 0 1", busya, synca);
        end
    endtask

    task automatic test_single;
        int d0;
        mon_sel = 0;
        d0 = done_cnt;
        send(0, 0, 0, 1'b1, 24'h188000);
        measure_busy("single", 101);
        wait_idle("single");
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL single_done_pulses: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_conversion;
        send(0, 1, 'h3FFF, 1'b1, 24'h197FFC);
        wait_idle("conv_neg");
        send(0, 0, 'h1FFF, 1'b1, 24'h18FFFC);
        send(0, 0, 'h2000, 1'b1, 24'h180000);
        wait_idle("conv_fullscale");
    endtask

    task automatic test_arbitration;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        send_pair('h0100, 'h0200, 1'b0);
        measure_gap("arb_pair0");
        wait_idle("arb_pair0");
        send(0, 0, 'h0155, 1'b1, exp_frame(0, 'h0155, 14));
        wait_idle("arb_single");
        send_pair('h0100, 'h0200, 1'b1);
        measure_gap("arb_pair1");
        wait_idle("arb_pair1");
    endtask

    task automatic test_backpressure;
        int t;
        @(negedge clk);
        v0a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d0a = 14'('h1FFE + k);
            t = 0;
            while (!r0a && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) begin
                n_vec++; n_err++;
                $display("FAIL bp_timeout: sample %0d not accepted", k);
            end else begin
                exp_q.push_back(exp_frame(0, 'h1FFE + k, 14));
            end
            @(negedge clk);
            n_vec++;
            if (r0a !== 1'b0) begin
                n_err++; $display("FAIL bp_rdy_when_full: sample %0d rdy0=%b, required 0", k, r0a);
            end
        end
        v0a = 1'b0;
        wait_idle("backpressure");
    endtask

    task automatic test_reset_mid_frame;
        int t, lows;
        send(0, 0, 'h0AAA, 1'b0, 24'h0);
        send(0, 1, 'h0555, 1'b0, 24'h0);
        t = 0;
        while (nb < 10 && t < 1000) begin @(negedge clk); t++; end
        n_vec++;
        if (r1a !== 1'b0 || synca !== 1'b0) begin
            n_err++; $display("FAIL midreset_pre: rdy1=%b sync=%b, required 0 0", r1a, synca);
        end
        reset_n = 1'b0;
        #1;
        n_vec += 2;
        if (synca !== 1'b1) begin n_err++; $display("FAIL midreset_sync: got %b, required 1", synca); end
        if (sclka !== 1'b1) begin n_err++; $display("FAIL midreset_sclk: got %b, required 1", sclka); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (r0a !== 1'b1 || r1a !== 1'b1) begin
            n_err++; $display("FAIL midreset_rdy: rdy0=%b rdy1=%b, required 1 1", r0a, r1a);
        end
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!synca || busya) lows++;
        end
        n_vec++;
        if (lows !== 0) begin
            n_err++; $display("FAIL midreset_no_frame: %0d active cycles, required 0", lows);
        end
    endtask

    task automatic test_sweep;
        mon_sel = 1;
        repeat (2) @(negedge clk);
        send(1, 0, 'h8000, 1'b1, 24'h180000);
        measure_busy("w16", 50);
        wait_idle("w16");
        mon_sel = 2;
        repeat (2) @(negedge clk);
        send(2, 1, 'h7FF, 1'b1, 24'h19FFF0);
        wait_idle("w12");
    endtask

    initial begin
        test_reset;
        test_single;
        test_conversion;
        test_arbitration;
        test_backpressure;
        test_reset_mid_frame;
        test_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

endmodule
